// File: rtl/audio_pkg.sv
// Shared types and the sound-effect table for the audio effect player.
// Each table word packs {decay, duration in ticks, half-period in clocks}.
package audio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int ROM_HALF_W    = 16;
    localparam int ROM_DUR_W     = 12;
    localparam int ROM_W         = 1 + ROM_DUR_W + ROM_HALF_W;
    localparam int ROM_HALF_LSB  = 0;
    localparam int ROM_DUR_LSB   = ROM_HALF_W;
    localparam int ROM_DECAY_BIT = ROM_HALF_W + ROM_DUR_W;

    typedef logic [ROM_W-1:0] rom_word_t;

    // Entry 0 is never played: a strobe with sel 0 means stop.
    localparam rom_word_t SOUND_TABLE [16] = '{
        {1'b0, 12'd0,    16'd0},
        {1'b0, 12'd8,    16'd3},
        {1'b1, 12'd100,  16'd2},
        {1'b0, 12'd1,    16'd1},
        {1'b0, 12'd120,  16'd56818},
        {1'b0, 12'd120,  16'd45097},
        {1'b0, 12'd120,  16'd37922},
        {1'b1, 12'd400,  16'd28409},
        {1'b1, 12'd800,  16'd50000},
        {1'b0, 12'd60,   16'd12500},
        {1'b0, 12'd60,   16'd8333},
        {1'b1, 12'd250,  16'd6250},
        {1'b0, 12'd30,   16'd25000},
        {1'b1, 12'd1500, 16'd62500},
        {1'b0, 12'd2000, 16'd20000},
        {1'b1, 12'd4000, 16'd0}
    };

endpackage

// File: rtl/audio_fx_rom.sv
// Combinational lookup of the sound table: sound index -> decay flag,
// duration (ticks) and half-period (clocks).
module audio_fx_rom
    import audio_pkg::*;
(
    input  logic [3:0]            sel,
    output logic                  decay,
    output logic [ROM_DUR_W-1:0]  dur,
    output logic [ROM_HALF_W-1:0] half
);

    rom_word_t word;

    assign word  = SOUND_TABLE[sel];
    assign decay = word[ROM_DECAY_BIT];
    assign dur   = word[ROM_DUR_LSB +: ROM_DUR_W];
    assign half  = word[ROM_HALF_LSB +: ROM_HALF_W];

endmodule

// File: rtl/audio_fx_player.sv
// Square-wave sound effect player: tone, duration and decay counters with a
// 5-bit sample output and a 31-step PWM stream for the speaker pin.
module audio_fx_player
    import audio_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int DECAY_TK = 16,
    parameter int HALF_W   = ROM_HALF_W,
    parameter int DUR_W    = ROM_DUR_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       audioEn,
    input  logic [3:0] audioSel,
    input  logic [4:0] audioVol,
    output logic [4:0] sample_out,
    output logic       pwm_out,
    output logic       busy,
    output logic       done
);

    localparam int TICK_W  = $clog2(TICK_DIV + 1);
    localparam int DECAY_W = $clog2(DECAY_TK + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_TK - 1);
    localparam logic [4:0]         PWM_LAST   = 5'd30;

    state_t              state_reg, state_next;
    logic [HALF_W-1:0]   half_cnt_reg, half_cnt_next;
    logic [HALF_W-1:0]   reload_reg, reload_next;
    logic [DUR_W-1:0]    dur_cnt_reg, dur_cnt_next;
    logic [TICK_W-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [DECAY_W-1:0]  decay_cnt_reg, decay_cnt_next;
    logic [4:0]          vol_reg, vol_next;
    logic                decay_en_reg, decay_en_next;
    logic                phase_reg, phase_next;
    logic                done_reg, done_next;
    logic [4:0]          sample_reg, sample_next;
    logic                pwm_reg, pwm_next;
    logic [4:0]          pwm_cnt_reg, pwm_cnt_next;
    logic                sound_end;

    logic                  rom_decay;
    logic [ROM_DUR_W-1:0]  rom_dur;
    logic [ROM_HALF_W-1:0] rom_half;
    logic [ROM_HALF_W-1:0] rom_reload;

    audio_fx_rom u_rom (
        .sel   (audioSel),
        .decay (rom_decay),
        .dur   (rom_dur),
        .half  (rom_half)
    );

    // A zero half-period behaves like 1: reload 0, toggle every clock.
    assign rom_reload = (rom_half == '0) ? '0 : rom_half - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            half_cnt_reg  <= '0;
            reload_reg    <= '0;
            dur_cnt_reg   <= '0;
            tick_cnt_reg  <= '0;
            decay_cnt_reg <= '0;
            vol_reg       <= '0;
            decay_en_reg  <= 1'b0;
            phase_reg     <= 1'b0;
            done_reg      <= 1'b0;
            sample_reg    <= '0;
            pwm_reg       <= 1'b0;
            pwm_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            half_cnt_reg  <= half_cnt_next;
            reload_reg    <= reload_next;
            dur_cnt_reg   <= dur_cnt_next;
            tick_cnt_reg  <= tick_cnt_next;
            decay_cnt_reg <= decay_cnt_next;
            vol_reg       <= vol_next;
            decay_en_reg  <= decay_en_next;
            phase_reg     <= phase_next;
            done_reg      <= done_next;
            sample_reg    <= sample_next;
            pwm_reg       <= pwm_next;
            pwm_cnt_reg   <= pwm_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        half_cnt_next  = half_cnt_reg;
        reload_next    = reload_reg;
        dur_cnt_next   = dur_cnt_reg;
        tick_cnt_next  = tick_cnt_reg;
        decay_cnt_next = decay_cnt_reg;
        vol_next       = vol_reg;
        decay_en_next  = decay_en_reg;
        phase_next     = phase_reg;
        done_next      = 1'b0;
        sound_end      = 1'b0;
        if (audioEn) begin
            if (audioSel != 4'd0) begin
                state_next     = PLAY;
                reload_next    = HALF_W'(rom_reload);
                half_cnt_next  = HALF_W'(rom_reload);
                dur_cnt_next   = DUR_W'(rom_dur);
                decay_en_next  = rom_decay;
                vol_next       = audioVol;
                tick_cnt_next  = '0;
                decay_cnt_next = '0;
                phase_next     = 1'b1;
            end else begin
                state_next = IDLE;
            end
        end else if (state_reg == PLAY) begin
            if (half_cnt_reg == '0) begin
                phase_next    = ~phase_reg;
                half_cnt_next = reload_reg;
            end else begin
                half_cnt_next = half_cnt_reg - 1'b1;
            end
            if (tick_cnt_reg == TICK_LAST) begin
                tick_cnt_next = '0;
                dur_cnt_next  = (dur_cnt_reg == '0) ? '0 : dur_cnt_reg - 1'b1;
                if (dur_cnt_next == '0) begin
                    sound_end = 1'b1;
                end
                if (decay_en_reg) begin
                    if (decay_cnt_reg == DECAY_LAST) begin
                        decay_cnt_next = '0;
                        vol_next       = (vol_reg == '0) ? '0 : vol_reg - 1'b1;
                        if (vol_next == '0) begin
                            sound_end = 1'b1;
                        end
                    end else begin
                        decay_cnt_next = decay_cnt_reg + 1'b1;
                    end
                end
            end else begin
                tick_cnt_next = tick_cnt_reg + 1'b1;
            end
            // Duration expiry and decay-to-zero share one end path, so one done pulse.
            if (sound_end) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end
    end

    // Sample and PWM are built from next-state values so they line up with busy.
    always_comb begin
        sample_next  = (state_next == PLAY && phase_next) ? vol_next : '0;
        pwm_next     = (sample_next > pwm_cnt_reg);
        pwm_cnt_next = (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + 1'b1;
    end

    assign sample_out = sample_reg;
    assign pwm_out    = pwm_reg;
    assign busy       = (state_reg == PLAY);
    assign done       = done_reg;

endmodule

// File: tb/tb_audio_fx_player.sv
// Directed bench for audio_fx_player with TICK_DIV=4, DECAY_TK=2 and the
// short sim sound table (sel1 tone, sel2 decaying, sel3 one-tick blip).
module tb_audio_fx_player;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       audioEn = 1'b0;
    logic [3:0] audioSel = 4'd0;
    logic [4:0] audioVol = 5'd0;
    logic [4:0] sample_out;
    logic       pwm_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    audio_fx_player #(
        .TICK_DIV (4),
        .DECAY_TK (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .audioEn    (audioEn),
        .audioSel   (audioSel),
        .audioVol   (audioVol),
        .sample_out (sample_out),
        .pwm_out    (pwm_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic strobe(input logic [3:0] sel, input logic [4:0] vol);
        audioSel = sel;
        audioVol = vol;
        audioEn  = 1'b1;
        step();
        audioEn  = 1'b0;
    endtask

    initial begin
        // T1: reset then idle
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1_rst_sample", k, 32'(sample_out), 0);
            chk("t1_rst_pwm", k, 32'(pwm_out), 0);
            chk("t1_rst_busy", k, 32'(busy), 0);
            chk("t1_rst_done", k, 32'(done), 0);
        end
        reset = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            chk("t1_idle_sample", k, 32'(sample_out), 0);
            chk("t1_idle_pwm", k, 32'(pwm_out), 0);
            chk("t1_idle_busy", k, 32'(busy), 0);
            chk("t1_idle_done", k, 32'(done), 0);
        end

        // T2: sel1 vol20, 3-clock half periods, 32-clock duration
        strobe(4'd1, 5'd20);
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) step();
            chk("t2_sample", k, 32'(sample_out), (k < 32 && (k / 3) % 2 == 0) ? 20 : 0);
            chk("t2_busy", k, 32'(busy), (k < 32) ? 1 : 0);
            chk("t2_done", k, 32'(done), (k == 32) ? 1 : 0);
        end

        // T3: full-scale PWM, then a silent run
        strobe(4'd1, 5'd31);
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) step();
            chk("t3_pwm31", k, 32'(pwm_out), (k < 32 && (k / 3) % 2 == 0) ? 1 : 0);
        end
        strobe(4'd1, 5'd0);
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) step();
            chk("t3_pwm0", k, 32'(pwm_out), 0);
            chk("t3_busy0", k, 32'(busy), (k < 32) ? 1 : 0);
            chk("t3_done0", k, 32'(done), (k == 32) ? 1 : 0);
        end

        // T4: sel2 decays 3,2,1,0 every 8 clocks and ends at 24
        strobe(4'd2, 5'd3);
        for (int k = 0; k <= 26; k++) begin
            if (k > 0) step();
            chk("t4_sample", k, 32'(sample_out), (k < 24 && (k / 2) % 2 == 0) ? (3 - k / 8) : 0);
            chk("t4_busy", k, 32'(busy), (k < 24) ? 1 : 0);
            chk("t4_done", k, 32'(done), (k == 24) ? 1 : 0);
        end

        // T5: retrigger sel1 -> sel3 after 10 clocks
        strobe(4'd1, 5'd20);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("t5_s1_done", k, 32'(done), 0);
            chk("t5_s1_busy", k, 32'(busy), 1);
        end
        strobe(4'd3, 5'd5);
        chk("t5_retrig_sample", 0, 32'(sample_out), 5);
        chk("t5_retrig_busy", 0, 32'(busy), 1);
        chk("t5_retrig_done", 0, 32'(done), 0);
        for (int j = 1; j <= 5; j++) begin
            step();
            chk("t5_s3_sample", j, 32'(sample_out), (j < 4 && j % 2 == 0) ? 5 : 0);
            chk("t5_s3_busy", j, 32'(busy), (j < 4) ? 1 : 0);
            chk("t5_s3_done", j, 32'(done), (j == 4) ? 1 : 0);
        end

        // T6a: stop strobe mid-sound
        strobe(4'd1, 5'd20);
        for (int k = 1; k <= 4; k++) step();
        strobe(4'd0, 5'd20);
        chk("t6_stop_sample", 0, 32'(sample_out), 0);
        chk("t6_stop_pwm", 0, 32'(pwm_out), 0);
        chk("t6_stop_busy", 0, 32'(busy), 0);
        chk("t6_stop_done", 0, 32'(done), 0);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("t6_stop_idle_done", k, 32'(done), 0);
            chk("t6_stop_idle_busy", k, 32'(busy), 0);
        end

        // T6b: reset mid-sound, then a fresh sound
        strobe(4'd1, 5'd31);
        for (int k = 1; k <= 5; k++) step();
        reset = 1'b1;
        step();
        chk("t6_rst_sample", 0, 32'(sample_out), 0);
        chk("t6_rst_pwm", 0, 32'(pwm_out), 0);
        chk("t6_rst_busy", 0, 32'(busy), 0);
        chk("t6_rst_done", 0, 32'(done), 0);
        reset = 1'b0;
        strobe(4'd1, 5'd20);
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) step();
            chk("t6_after_sample", k, 32'(sample_out), (k < 32 && (k / 3) % 2 == 0) ? 20 : 0);
            chk("t6_after_busy", k, 32'(busy), (k < 32) ? 1 : 0);
            chk("t6_after_done", k, 32'(done), (k == 32) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
